keypad_scan_ctrl: RTL and testbench

//  Scan controller for the 4x4 matrix keypad. Drives one column at a time,

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/keypad_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : shared types, key map and helpers for the 4x4 keypad scanner
// Revision   : 1.0
// ============================================================================
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   // Indexed [row][col]; row 3 carries the E/0/F/D keys of the bottom line.
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] row_index(input logic [3:0] onehot);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (onehot[i]) idx = i[1:0];
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : two-flop synchronizer bringing the raw keypad rows into int_osc
// Revision : 1.0
// ============================================================================
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             int_osc,
   input  logic             nrst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge int_osc or negedge nrst) begin
      if (!nrst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// keypad_scan_ctrl : 4x4 keypad column scanner with press/release debounce
// Revision         : 1.0
// ============================================================================
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 20000
) (
   input  logic       int_osc,
   input  logic       nrst,
   input  logic [3:0] row_d,
   output logic [3:0] column_signals,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CNT);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

   scan_state_t      state;
   scan_state_t      next_state;
   logic [3:0]       rs;
   logic [1:0]       col_idx;
   logic [DIV_W-1:0] div_cnt;
   logic [DEB_W-1:0] deb_cnt;
   logic [3:0]       cap_row;
   logic [1:0]       cap_col;

   logic             rs_onehot;
   logic             row_match;
   logic             div_done;
   logic             deb_done;
   logic             capture;
   logic             accept;
   logic             advance_col;

   sync_2ff #(
      .WIDTH (4)
   ) u_row_sync (
      .int_osc (int_osc),
      .nrst    (nrst),
      .d       (row_d),
      .q       (rs)
   );

   assign rs_onehot = is_onehot(rs);
   assign row_match = (rs == cap_row);
   assign div_done  = (div_cnt == DIV_LAST);
   assign deb_done  = (deb_cnt == DEB_LAST);

   assign capture = (state == SCAN) && div_done && rs_onehot;
   assign accept  = (state == DEBOUNCE) && row_match && deb_done;

   // The column moves on only when a slot ends empty, a press aborts, or a
   // release completes; otherwise it stays parked on the captured key.
   assign advance_col = ((state == SCAN)     && div_done && !rs_onehot) ||
                        ((state == DEBOUNCE) && !row_match)             ||
                        ((state == RELEASE)  && !row_match && deb_done);

   always_ff @(posedge int_osc or negedge nrst) begin
      if (!nrst) begin
         state <= SCAN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         SCAN: begin
            if (div_done && rs_onehot) next_state = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!row_match)    next_state = SCAN;
            else if (deb_done) next_state = HOLD;
         end
         HOLD: begin
            if (!row_match) next_state = RELEASE;
         end
         RELEASE: begin
            if (row_match)     next_state = HOLD;
            else if (deb_done) next_state = SCAN;
         end
         default: next_state = SCAN;
      endcase
   end

   always_comb begin
      column_signals = 4'b0001 << col_idx;
   end

   always_ff @(posedge int_osc or negedge nrst) begin
      if (!nrst) begin
         col_idx   <= 2'd0;
         div_cnt   <= '0;
         deb_cnt   <= '0;
         cap_row   <= 4'd0;
         cap_col   <= 2'd0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
      end else begin
         key_valid <= accept;

         if (accept) begin
            key_code <= KEY_MAP[row_index(cap_row)][cap_col];
         end

         if (advance_col) begin
            col_idx <= col_idx + 2'd1;
         end

         if (capture) begin
            cap_row <= rs;
            cap_col <= col_idx;
         end

         if ((state == SCAN) && !div_done) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end else begin
            div_cnt <= '0;
         end

         // deb_cnt measures a continuous run: matching rows while debouncing
         // a press, non-matching rows while debouncing a release.
         case (state)
            DEBOUNCE: begin
               if (row_match && !deb_done) deb_cnt <= deb_cnt + DEB_W'(1);
               else                        deb_cnt <= '0;
            end
            RELEASE: begin
               if (!row_match && !deb_done) deb_cnt <= deb_cnt + DEB_W'(1);
               else                         deb_cnt <= '0;
            end
            default: deb_cnt <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keypad_scan_ctrl : directed + random bench against a timeline model
// Revision            : 1.0
// ============================================================================
module tb_keypad_scan_ctrl;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;

   localparam int HUNT      = 0;
   localparam int CONFIRM   = 1;
   localparam int HELD      = 2;
   localparam int RELEASING = 3;

   logic       int_osc = 1'b0;
   logic       nrst    = 1'b0;
   logic [3:0] row_d   = 4'd0;
   logic [3:0] column_signals;
   logic       key_valid;
   logic [3:0] key_code;

   int n_cmp = 0;
   int n_bad = 0;

   keypad_scan_ctrl #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .int_osc        (int_osc),
      .nrst           (nrst),
      .row_d          (row_d),
      .column_signals (column_signals),
      .key_valid      (key_valid),
      .key_code       (key_code)
   );

   always #5 int_osc = ~int_osc;

   // Reference model: elapsed-time view of the scanner
   logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                           4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC,
                           4'hE, 4'h0, 4'hF, 4'hD};
   int         m_mode = HUNT;
   int         m_col = 0, m_wait = 0, m_stable = 0, m_ridx = 0;
   logic [3:0] m_cap = 0, m_code = 0, s1 = 0, s2 = 0, m_rs = 0;
   logic       m_valid = 0;

   always @(posedge int_osc or negedge nrst) begin
      if (!nrst) begin
         m_mode = HUNT; m_col = 0; m_wait = 0; m_stable = 0;
         m_cap = 0; m_code = 0; s1 = 0; s2 = 0; m_valid = 0;
      end else begin
         m_rs = s2;
         s2 = s1;
         s1 = row_d;
         m_valid = 1'b0;
         case (m_mode)
            HUNT: begin
               if (m_wait == SCAN_DIV - 1) begin
                  m_wait = 0;
                  if ($countones(m_rs) == 1) begin
                     m_cap = m_rs; m_stable = 0; m_mode = CONFIRM;
                  end else begin
                     m_col = (m_col + 1) % 4;
                  end
               end else begin
                  m_wait++;
               end
            end
            CONFIRM: begin
               if (m_rs !== m_cap) begin
                  m_mode = HUNT; m_col = (m_col + 1) % 4; m_wait = 0;
               end else begin
                  m_stable++;
                  if (m_stable == DEBOUNCE_CNT) begin
                     m_ridx = 0;
                     for (int b = 0; b < 4; b++) if (m_cap[b]) m_ridx = b;
                     m_valid = 1'b1;
                     m_code  = km[m_ridx*4 + m_col];
                     m_mode  = HELD;
                  end
               end
            end
            HELD: begin
               if (m_rs !== m_cap) begin
                  m_stable = 0; m_mode = RELEASING;
               end
            end
            default: begin
               if (m_rs === m_cap) begin
                  m_mode = HELD;
               end else begin
                  m_stable++;
                  if (m_stable == DEBOUNCE_CNT) begin
                     m_mode = HUNT; m_col = (m_col + 1) % 4; m_wait = 0;
                  end
               end
            end
         endcase
      end
   end

   function automatic logic [8:0] model_out();
      logic [3:0] c;
      c = 4'b0001 << m_col;
      return {c, m_valid, m_code};
   endfunction

   task automatic test_reset();
      nrst = 1'b0; row_d = 4'd0;
      repeat (2) @(negedge int_osc);
      n_cmp++;
      if ({column_signals, key_valid, key_code} !== 9'b0001_0_0000) begin
         n_bad++;
         $display("FAIL reset_hold: got %b want %b", {column_signals, key_valid, key_code}, 9'b0001_0_0000);
      end
      nrst = 1'b1;
      repeat (6) @(negedge int_osc);
      n_cmp++;
      if (column_signals !== 4'b0010) begin
         n_bad++;
         $display("FAIL pre_reset_col: got %b want %b", column_signals, 4'b0010);
      end
      #2 nrst = 1'b0;
      #1;
      n_cmp++;
      if ({column_signals, key_valid, key_code} !== 9'b0001_0_0000) begin
         n_bad++;
         $display("FAIL async_reset: got %b want %b", {column_signals, key_valid, key_code}, 9'b0001_0_0000);
      end
      @(negedge int_osc);
   endtask

   task automatic test_scan_rotation();
      logic [3:0] want;
      nrst = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) @(negedge int_osc);
         n_cmp++;
         if ({column_signals, key_valid, key_code} !== model_out()) begin
            n_bad++;
            $display("FAIL rotate_model k=%0d: got %b want %b", k, {column_signals, key_valid, key_code}, model_out());
         end
         if (k % 4 == 0) begin
            want = 4'b0001 << ((k / 4) % 4);
            n_cmp++;
            if (column_signals !== want) begin
               n_bad++;
               $display("FAIL rotate_col k=%0d: got %b want %b", k, column_signals, want);
            end
         end
      end
   endtask

   task automatic test_press();
      bit ok;
      int strobes, frozen_bad;
      logic [3:0] code_seen;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge int_osc); ok = (column_signals == 4'b0001); end
      for (int i = 0; i < 40 && ok; i++) begin @(negedge int_osc); if (column_signals == 4'b0010) break; if (i == 39) ok = 0; end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL press_wait: got timeout want column 0010"); end
      row_d = 4'b0001; strobes = 0; frozen_bad = 0; code_seen = 4'h0;
      repeat (40) begin
         @(negedge int_osc);
         n_cmp++;
         if ({column_signals, key_valid, key_code} !== model_out()) begin
            n_bad++;
            $display("FAIL press_model: got %b want %b", {column_signals, key_valid, key_code}, model_out());
         end
         if (key_valid) begin strobes++; code_seen = key_code; end
         if (column_signals !== 4'b0010) frozen_bad++;
      end
      row_d = 4'b0000;
      for (int j = 1; j <= 12; j++) begin
         @(negedge int_osc);
         n_cmp++;
         if ({column_signals, key_valid, key_code} !== model_out()) begin
            n_bad++;
            $display("FAIL release_model j=%0d: got %b want %b", j, {column_signals, key_valid, key_code}, model_out());
         end
         if (j == 8) begin
            n_cmp++;
            if (column_signals !== 4'b0010) begin
               n_bad++; $display("FAIL release_frozen: got %b want %b", column_signals, 4'b0010);
            end
         end
      end
      n_cmp++;
      if (column_signals !== 4'b0100) begin n_bad++; $display("FAIL release_resume: got %b want %b", column_signals, 4'b0100); end
      n_cmp++;
      if (strobes !== 1) begin n_bad++; $display("FAIL press_strobes: got %0d want %0d", strobes, 1); end
      n_cmp++;
      if (code_seen !== 4'h2) begin n_bad++; $display("FAIL press_code: got %h want %h", code_seen, 4'h2); end
      n_cmp++;
      if (frozen_bad !== 0) begin n_bad++; $display("FAIL press_frozen: got %0d moves want %0d", frozen_bad, 0); end
   endtask

   task automatic test_short_press();
      bit ok, saw_col0;
      int strobes;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge int_osc); ok = (column_signals == 4'b0100); end
      for (int i = 0; i < 40 && ok; i++) begin @(negedge int_osc); if (column_signals == 4'b1000) break; if (i == 39) ok = 0; end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL short_wait: got timeout want column 1000"); end
      strobes = 0; saw_col0 = 0;
      for (int j = 0; j < 30; j++) begin
         row_d = (j < 5) ? 4'b0100 : 4'b0000;
         @(negedge int_osc);
         n_cmp++;
         if ({column_signals, key_valid, key_code} !== model_out()) begin
            n_bad++;
            $display("FAIL short_model j=%0d: got %b want %b", j, {column_signals, key_valid, key_code}, model_out());
         end
         if (key_valid) strobes++;
         if (column_signals == 4'b0001) saw_col0 = 1;
      end
      n_cmp++;
      if (strobes !== 0) begin n_bad++; $display("FAIL short_strobes: got %0d want %0d", strobes, 0); end
      n_cmp++;
      if (!saw_col0) begin n_bad++; $display("FAIL short_resume: got no column 0001 want 0001"); end
      n_cmp++;
      if (key_code !== 4'h2) begin n_bad++; $display("FAIL short_code_kept: got %h want %h", key_code, 4'h2); end
   endtask

   task automatic test_multi_row();
      int strobes, moves;
      logic [3:0] prev;
      row_d = 4'b0011; strobes = 0; moves = 0; prev = column_signals;
      repeat (40) begin
         @(negedge int_osc);
         n_cmp++;
         if ({column_signals, key_valid, key_code} !== model_out()) begin
            n_bad++;
            $display("FAIL multi_model: got %b want %b", {column_signals, key_valid, key_code}, model_out());
         end
         if (key_valid) strobes++;
         if (column_signals != prev) moves++;
         prev = column_signals;
      end
      row_d = 4'b0000;
      n_cmp++;
      if (strobes !== 0) begin n_bad++; $display("FAIL multi_strobes: got %0d want %0d", strobes, 0); end
      n_cmp++;
      if (moves < 9) begin n_bad++; $display("FAIL multi_rotate: got %0d moves want >=9", moves); end
   endtask

   task automatic test_bounce_and_reset();
      bit ok;
      int strobes;
      logic [3:0] code_seen;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge int_osc); ok = (column_signals == 4'b0001); end
      for (int i = 0; i < 40 && ok; i++) begin @(negedge int_osc); if (column_signals == 4'b0010) break; if (i == 39) ok = 0; end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL bounce_wait: got timeout want column 0010"); end
      strobes = 0; code_seen = 4'h0;
      for (int j = 0; j < 84; j++) begin
         row_d = (j < 30 || (j >= 34 && j < 54)) ? 4'b0010 : 4'b0000;
         @(negedge int_osc);
         n_cmp++;
         if ({column_signals, key_valid, key_code} !== model_out()) begin
            n_bad++;
            $display("FAIL bounce_model j=%0d: got %b want %b", j, {column_signals, key_valid, key_code}, model_out());
         end
         if (key_valid) begin strobes++; code_seen = key_code; end
      end
      n_cmp++;
      if (strobes !== 1) begin n_bad++; $display("FAIL bounce_strobes: got %0d want %0d", strobes, 1); end
      n_cmp++;
      if (code_seen !== 4'h5) begin n_bad++; $display("FAIL bounce_code: got %h want %h", code_seen, 4'h5); end

      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge int_osc); ok = (column_signals == 4'b0001); end
      for (int i = 0; i < 40 && ok; i++) begin @(negedge int_osc); if (column_signals == 4'b0010) break; if (i == 39) ok = 0; end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL deb_reset_wait: got timeout want column 0010"); end
      row_d = 4'b0010;
      repeat (6) @(negedge int_osc);
      #2 nrst = 1'b0; row_d = 4'b0000;
      #1;
      n_cmp++;
      if ({column_signals, key_valid, key_code} !== 9'b0001_0_0000) begin
         n_bad++;
         $display("FAIL deb_reset_now: got %b want %b", {column_signals, key_valid, key_code}, 9'b0001_0_0000);
      end
      repeat (2) @(negedge int_osc);
      nrst = 1'b1;
      strobes = 0;
      repeat (30) begin
         @(negedge int_osc);
         n_cmp++;
         if ({column_signals, key_valid, key_code} !== model_out()) begin
            n_bad++;
            $display("FAIL deb_reset_model: got %b want %b", {column_signals, key_valid, key_code}, model_out());
         end
         if (key_valid) strobes++;
      end
      n_cmp++;
      if (strobes !== 0 || key_code !== 4'h0) begin
         n_bad++;
         $display("FAIL deb_reset_after: got strobes=%0d code=%h want strobes=0 code=0", strobes, key_code);
      end
   endtask

   task automatic test_random();
      logic [3:0] val, prev_code;
      logic       prev_valid;
      int         dur, sel;
      prev_valid = 1'b0; prev_code = key_code;
      for (int seg = 0; seg < 60; seg++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4)      val = 4'b0000;
         else if (sel < 8) val = 4'b0001 << $urandom_range(0, 3);
         else              val = 4'($urandom_range(0, 15));
         dur = $urandom_range(1, 40);
         row_d = val;
         repeat (dur) begin
            @(negedge int_osc);
            n_cmp++;
            if ({column_signals, key_valid, key_code} !== model_out()) begin
               n_bad++;
               $display("FAIL random_model seg=%0d: got %b want %b", seg, {column_signals, key_valid, key_code}, model_out());
            end
            n_cmp++;
            if ((key_valid && prev_valid) || (key_code !== prev_code && !key_valid)) begin
               n_bad++;
               $display("FAIL random_strobe_rule seg=%0d: got valid=%b/%b code=%h/%h want single strobe with code change", seg, prev_valid, key_valid, prev_code, key_code);
            end
            prev_valid = key_valid;
            prev_code  = key_code;
         end
      end
      row_d = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_scan_rotation();
      test_press();
      test_short_press();
      test_multi_row();
      test_bounce_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
